amp_drive_mc: RTL

Multi-channel, parametrised feed-forward amplifier drive stage. It sits between the feed-forward loop/gain output and the DAC pins. Each channel's drive word is latency-aligned with a programmable delay, gated to a processing window within the store strobe, and mode-selected (sample, constant, or new baseline-removal). The result is scaled to DAC width with saturation, and then decimated into DAC data plus a DAC clock enable. Compared with the single-channel fixed-width stage, it adds a channel count, width and decimation parameters, saturation with sticky per-channel flags, and an explicit output state machine.

---
 rtl/amp_drive_mc.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/amp_drive_mc.sv
// ---------------------------------------------------------------------------
// amp_drive_mc : multi-channel feed-forward amplifier DAC drive stage.
//
// Each channel's drive word is latency-aligned by a programmable delay,
// gated to a processing window inside the store strobe, mode-selected
// (sample / constant / baseline-removed / zero), scaled to DAC width with
// saturation, and decimated into DAC words plus a DAC clock enable.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   store_strb          pulse window from the trigger logic
//   feedfwd_en          global output enable (2-flop synchronised inside)
//   use_strobes         1 = apply gate window, 0 = whole strobe is active
//   start_proc/end_proc gate window bounds in delayed-strobe cycles
//   ldelay              latency delay, captured at the strobe rising edge
//   op_mode             0 sample, 1 constant, 2 baseline-removed, 3 zero
//   const_dac_val       per-channel constant, channel c at [c*OW +: OW]
//   din                 per-channel samples, channel c at [c*DW +: DW]
//   dac_clk_phase       inverts the dac_en phase while running
//   oflow_clr           clears the sticky saturation flags
//   dout, dac_en        registered DAC words and DAC clock enable
//   oflow_detect        sticky per-channel saturation flags
//   busy                output FSM is not IDLE
// ---------------------------------------------------------------------------
module amp_drive_mc #(
    parameter int NCH   = 2,
    parameter int DW    = 16,
    parameter int OW    = 13,
    parameter int DEPTH = 32,
    parameter int CW    = 10,
    parameter int DEC   = 2,
    localparam int LW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              store_strb,
    input  logic              feedfwd_en,
    input  logic              use_strobes,
    input  logic [CW-1:0]     start_proc,
    input  logic [CW-1:0]     end_proc,
    input  logic [LW-1:0]     ldelay,
    input  logic [1:0]        op_mode,
    input  logic [NCH*OW-1:0] const_dac_val,
    input  logic [NCH*DW-1:0] din,
    input  logic              dac_clk_phase,
    input  logic              oflow_clr,
    output logic [NCH*OW-1:0] dout,
    output logic              dac_en,
    output logic [NCH-1:0]    oflow_detect,
    output logic              busy
);

    localparam int SH  = DW - OW;
    localparam int DCW = $clog2(DEC);
    localparam logic [DCW-1:0] DEC_LAST = DCW'(DEC - 1);
    localparam logic [DCW-1:0] DEC_HALF = DCW'(DEC / 2);
    localparam logic signed [DW:0] SAT_HI = {{(DW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [DW:0] SAT_LO = {{(DW+2-OW){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    // Constant is sign-extended to the stage-1 width and lifted to input scale.
    function automatic logic signed [DW:0] stage1_sel(input logic [1:0] mode,
                                                      input logic signed [DW-1:0] smp,
                                                      input logic signed [DW-1:0] bl,
                                                      input logic signed [OW-1:0] cv);
        logic signed [DW:0] cext;
        cext = {{(DW+1-OW){cv[OW-1]}}, cv};
        case (mode)
            2'd0:    stage1_sel = {smp[DW-1], smp};
            2'd1:    stage1_sel = cext <<< SH;
            2'd2:    stage1_sel = {smp[DW-1], smp} - {bl[DW-1], bl};
            default: stage1_sel = '0;
        endcase
    endfunction

    // Returns {clipped, word}.
    function automatic logic [OW:0] scale_sat(input logic signed [DW:0] v);
        logic signed [DW:0] sh;
        sh = v >>> SH;
        if (sh > SAT_HI)      scale_sat = {1'b1, 1'b0, {(OW-1){1'b1}}};
        else if (sh < SAT_LO) scale_sat = {1'b1, 1'b1, {(OW-1){1'b0}}};
        else                  scale_sat = {1'b0, sh[OW-1:0]};
    endfunction

    // ---------------- latency delay ----------------
    logic              strb_prev, armed, strb_rise, strb_in, strb_d;
    logic [LW-1:0]     ldelay_q, dly, wp, rp;
    logic [DEPTH-1:0]  strb_hist;
    logic [NCH*DW-1:0] din_mem [DEPTH];
    logic [NCH*DW-1:0] din_d_flat;

    // A strobe already high when reset releases is not a rising edge; it is
    // masked until the next genuine rise re-arms the path.
    assign strb_rise = store_strb & ~strb_prev;
    assign strb_in   = store_strb & (armed | strb_rise);
    // The rising-edge cycle already uses the newly captured delay.
    assign dly        = strb_rise ? ldelay : ldelay_q;
    assign rp         = wp - dly;
    assign strb_d     = (dly == '0) ? strb_in : strb_hist[rp];
    assign din_d_flat = (dly == '0) ? din : din_mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_prev <= 1'b1;
            armed     <= 1'b0;
            ldelay_q  <= '0;
            wp        <= '0;
            strb_hist <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            strb_prev <= store_strb;
            if (strb_rise) begin
                armed    <= 1'b1;
                ldelay_q <= ldelay;
            end else if (!store_strb) begin
                armed <= 1'b0;
            end
            wp            <= wp + 1'b1;
            strb_hist[wp] <= strb_in;
        end
    end

    // NOTE: sample storage has no reset; only the strobe history must be clean after reset.
    always_ff @(posedge clk) begin
        din_mem[wp] <= din;
    end

    // ---------------- gate counter ----------------
    logic [CW-1:0] cnt;
    logic          gate, act;

    assign gate = strb_d & (cnt >= start_proc) & (cnt < end_proc);
    assign act  = use_strobes ? gate : strb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (!strb_d)    cnt <= '0;
        else if (cnt != '1)  cnt <= cnt + 1'b1;
    end

    // ---------------- baseline, stage 1, stage 2 ----------------
    logic signed [DW-1:0] din_d   [NCH];
    logic signed [OW-1:0] cval    [NCH];
    logic signed [DW-1:0] base    [NCH];
    logic signed [DW:0]   sel_nxt [NCH];
    logic signed [DW:0]   sel_q   [NCH];
    logic [OW-1:0]        scl_nxt [NCH];
    logic [OW-1:0]        scl_q   [NCH];
    logic [NCH-1:0]       clip;
    logic [NCH*OW-1:0]    scl_flat;
    logic                 base_vld;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        clip     = '0;
        scl_flat = '0;
        for (int c = 0; c < NCH; c++) begin
            din_d[c] = din_d_flat[c*DW +: DW];
            cval[c]  = const_dac_val[c*OW +: OW];
            // Before the baseline register loads, the current sample is the baseline.
            sel_nxt[c] = act ? stage1_sel(op_mode, din_d[c],
                                          base_vld ? base[c] : din_d[c], cval[c]) : '0;
            {clip[c], scl_nxt[c]} = scale_sat(sel_q[c]);
            scl_flat[c*OW +: OW]  = scl_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_vld     <= 1'b0;
            oflow_detect <= '0;
            for (int c = 0; c < NCH; c++) begin
                base[c]  <= '0;
                sel_q[c] <= '0;
                scl_q[c] <= '0;
            end
        end else begin
            if (!strb_d)  base_vld <= 1'b0;
            else if (act) base_vld <= 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (act && !base_vld) base[c] <= din_d[c];
                sel_q[c] <= sel_nxt[c];
                scl_q[c] <= scl_nxt[c];
            end
            // A new clip in the clearing cycle keeps its flag.
            oflow_detect <= (oflow_detect & ~{NCH{oflow_clr}}) | clip;
        end
    end

    // ---------------- output FSM ----------------
    logic              strb_p1, strb_p, fen_s1, fen;
    state_t            state_q, state_nxt;
    logic [DCW-1:0]    dec_q, dec_nxt;
    logic [NCH*OW-1:0] dout_nxt;
    logic              dac_en_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_p1 <= 1'b0;
            strb_p  <= 1'b0;
            fen_s1  <= 1'b0;
            fen     <= 1'b0;
            state_q <= IDLE;
            dec_q   <= '0;
            dout    <= '0;
            dac_en  <= 1'b0;
        end else begin
            strb_p1 <= strb_d;
            strb_p  <= strb_p1;
            fen_s1  <= feedfwd_en;
            fen     <= fen_s1;
            state_q <= state_nxt;
            dec_q   <= dec_nxt;
            dout    <= dout_nxt;
            dac_en  <= dac_en_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        dec_nxt   = '0;
        case (state_q)
            IDLE:  if (strb_p && fen) state_nxt = RUN;
            RUN: begin
                if (!fen)         state_nxt = IDLE;
                else if (!strb_p) state_nxt = CLEAR;
                else              dec_nxt = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
            end
            CLEAR: state_nxt = (strb_p && fen) ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the first RUN cycle
    // already presents the stage-2 word.
    always_comb begin
        dout_nxt   = dout;
        dac_en_nxt = 1'b0;
        case (state_nxt)
            RUN: begin
                if (dec_nxt == '0) dout_nxt = scl_flat;
                dac_en_nxt = (dec_nxt >= DEC_HALF) ^ dac_clk_phase;
            end
            CLEAR: begin
                dout_nxt   = '0;
                dac_en_nxt = 1'b1;
            end
            default: dout_nxt = '0;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule
